// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM encoding, NOP word, bus response codes.
package riscv_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ADDR = ST_ADDR,
    DATA = ST_DATA,
    DONE = ST_DONE
  } fetch_state_e;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

endpackage

// File: rtl/inst_fetch_reg_timer.sv
// Saturating bus-phase cycle counter for the fetch stage.
module fetch_timer #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // expired fires on the TIMEOUT-th enabled cycle, counting the current one
  assign expired_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && cnt_q != LAST)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/inst_fetch_reg.sv
// Instruction fetch stage: one AXI4-Lite-style read per request, NOP on error.
// Optional FETCH_ALIGN_CHECK_EN rejects misaligned pc without a bus access.
module inst_fetch_reg #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST,
  parameter int          TIMEOUT  = 255,
  parameter int          CNT_W    = 8
) (
  input  logic              clock,
  input  logic              resetFetch,
  input  logic              enableFetch,
  input  logic [ADDR_W-1:0] pc,
  output logic              mem_arvalid,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_arready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic [1:0]        mem_rresp,
  output logic              mem_rready,
  output logic [31:0]       inst,
  output logic              enableDec,
  output logic              busy,
  output logic              fetch_err,
  output logic              misaligned
);

  import riscv_pkg::*;

  fetch_state_e      state_q;
  logic              arvalid_q;
  logic              rready_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [31:0]       inst_q;
  logic              dec_q;
  logic              busy_q;
  logic              err_q;
  logic              mis_q;
  logic              tmo;
  logic              start;

  assign start = (state_q == IDLE) && enableFetch;

  fetch_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clock),
    .rst_i     (resetFetch),
    .clr_i     (start),
    .en_i      ((state_q == ADDR) || (state_q == DATA)),
    .expired_o (tmo)
  );

  always_ff @(posedge clock or posedge resetFetch) begin
    if (resetFetch) begin
      state_q   <= IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
      inst_q    <= NOP_INST;
      dec_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      dec_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (enableFetch) begin
            err_q  <= 1'b0;
            mis_q  <= 1'b0;
            busy_q <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            araddr_q <= pc;
            if (pc[1:0] != 2'b00) begin
              inst_q  <= NOP_INST;
              mis_q   <= 1'b1;
              err_q   <= 1'b1;
              dec_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ADDR;
            end
`else
            araddr_q  <= pc & ~ADDR_W'(3);
            arvalid_q <= 1'b1;
            state_q   <= ADDR;
`endif
          end
        end
        ADDR: begin
          // handshake takes priority over a coinciding timeout
          if (mem_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end else if (tmo) begin
            arvalid_q <= 1'b0;
            inst_q    <= NOP_INST;
            err_q     <= 1'b1;
            dec_q     <= 1'b1;
            state_q   <= DONE;
          end
        end
        DATA: begin
          if (mem_rvalid) begin
            rready_q <= 1'b0;
            dec_q    <= 1'b1;
            state_q  <= DONE;
            if (mem_rresp == RESP_OKAY) begin
              inst_q <= mem_rdata;
            end else begin
              inst_q <= NOP_INST;
              err_q  <= 1'b1;
            end
          end else if (tmo) begin
            rready_q <= 1'b0;
            inst_q   <= NOP_INST;
            err_q    <= 1'b1;
            dec_q    <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_arvalid = arvalid_q;
  assign mem_araddr  = araddr_q;
  assign mem_rready  = rready_q;
  assign inst        = inst_q;
  assign enableDec   = dec_q;
  assign busy        = busy_q;
  assign fetch_err   = err_q;
  assign misaligned  = mis_q;

endmodule

// File: tb/tb_inst_fetch_reg.sv
// Directed bench for inst_fetch_reg with an expected-result scoreboard.
module tb_inst_fetch_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        resetFetch;
  logic        enableFetch;
  logic [31:0] pc;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rready;
  logic [31:0] inst;
  logic        enableDec;
  logic        busy;
  logic        fetch_err;
  logic        misaligned;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  inst_fetch_reg #(
    .ADDR_W   (32),
    .NOP_INST (NOP),
    .TIMEOUT  (8),
    .CNT_W    (8)
  ) dut (
    .clock       (clock),
    .resetFetch  (resetFetch),
    .enableFetch (enableFetch),
    .pc          (pc),
    .mem_arvalid (mem_arvalid),
    .mem_araddr  (mem_araddr),
    .mem_arready (mem_arready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp),
    .mem_rready  (mem_rready),
    .inst        (inst),
    .enableDec   (enableDec),
    .busy        (busy),
    .fetch_err   (fetch_err),
    .misaligned  (misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!resetFetch && enableDec === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_dec", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_inst", inst, e.inst);
        chk("sb_err", {31'd0, fetch_err}, {31'd0, e.err});
        chk("sb_mis", {31'd0, misaligned}, {31'd0, e.mis});
      end
    end
  end

  // wait < 0 means the bus never responds on that channel
  task automatic run_fetch(input logic [31:0] pc_v, input int ar_wait,
                           input int r_wait, input logic [31:0] d,
                           input logic [1:0] rsp, input logic [31:0] exp_addr,
                           output int busy_cyc, output int dec_cnt,
                           output int dec_at, output int av_cyc);
    int ac = 0;
    int rc = 0;
    bit done = 0;
    busy_cyc = 0;
    dec_cnt  = 0;
    dec_at   = 0;
    av_cyc   = 0;
    @(negedge clock);
    enableFetch = 1'b1;
    pc = pc_v;
    @(negedge clock);
    enableFetch = 1'b0;
    pc = 32'hFFFF_FFFF;
    for (int t = 1; t <= 40; t++) begin
      if (busy !== 1'b1) begin
        done = 1;
        break;
      end
      busy_cyc++;
      if (enableDec === 1'b1) begin
        dec_cnt++;
        dec_at = t;
      end
      if (mem_arvalid === 1'b1) begin
        av_cyc++;
        chk("araddr", mem_araddr, exp_addr);
      end
      mem_arready = (mem_arvalid === 1'b1) && (ac == ar_wait);
      if (mem_arvalid === 1'b1) ac++;
      if (mem_rready === 1'b1) begin
        mem_rvalid = (rc == r_wait);
        mem_rdata  = d;
        mem_rresp  = rsp;
        rc++;
      end else begin
        mem_rvalid = (mem_arvalid === 1'b1);
        mem_rdata  = 32'hBAD0_BAD0;
        mem_rresp  = 2'b11;
      end
      @(negedge clock);
    end
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    if (!done) chk("fetch_bound", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int bc, dc, da, av;
    resetFetch  = 1'b1;
    enableFetch = 1'b0;
    pc          = '0;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    mem_rresp   = 2'b00;

    #3;
    chk("rst_arvalid", {31'd0, mem_arvalid}, 32'd0);
    chk("rst_rready", {31'd0, mem_rready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dec", {31'd0, enableDec}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    chk("rst_araddr", mem_araddr, 32'd0);
    chk("rst_inst", inst, NOP);
    @(negedge clock);
    resetFetch = 1'b0;

    // minimum latency, enableDec on cycle 3
    sb.push_back('{32'h00A0_0093, 1'b0, 1'b0});
    run_fetch(32'h100, 0, 0, 32'h00A0_0093, 2'b00, 32'h100, bc, dc, da, av);
    chk("t1_busy", bc, 3);
    chk("t1_dec_cnt", dc, 1);
    chk("t1_dec_at", da, 3);
    chk("t1_av", av, 1);

    // delayed handshakes; rvalid coincides with the 8th bus cycle
    sb.push_back('{32'h1234_5678, 1'b0, 1'b0});
    run_fetch(32'h2000, 4, 2, 32'h1234_5678, 2'b00, 32'h2000, bc, dc, da, av);
    chk("t2_busy", bc, 9);
    chk("t2_dec_cnt", dc, 1);
    chk("t2_dec_at", da, 9);
    chk("t2_av", av, 5);

    // error response
    sb.push_back('{NOP, 1'b1, 1'b0});
    run_fetch(32'h300, 0, 0, 32'hDEAD_BEEF, 2'b10, 32'h300, bc, dc, da, av);
    chk("t3_dec_cnt", dc, 1);
    repeat (3) @(negedge clock);
    chk("t3_err_sticky", {31'd0, fetch_err}, 32'd1);
    chk("t3_inst_held", inst, NOP);

    // address-phase timeout
    sb.push_back('{NOP, 1'b1, 1'b0});
    run_fetch(32'h400, -1, 0, 32'h0, 2'b00, 32'h400, bc, dc, da, av);
    chk("t4_av", av, 8);
    chk("t4_busy", bc, 9);
    chk("t4_dec_cnt", dc, 1);
    chk("t4_arvalid_after", {31'd0, mem_arvalid}, 32'd0);

    // data-phase timeout
    sb.push_back('{NOP, 1'b1, 1'b0});
    run_fetch(32'h500, 0, -1, 32'h0, 2'b00, 32'h500, bc, dc, da, av);
    chk("t4b_busy", bc, 9);
    chk("t4b_dec_cnt", dc, 1);

    // misaligned pc
`ifdef FETCH_ALIGN_CHECK_EN
    sb.push_back('{NOP, 1'b1, 1'b1});
    run_fetch(32'h102, 0, 0, 32'hCAFE_F00D, 2'b00, 32'h102, bc, dc, da, av);
    chk("t6_av", av, 0);
    chk("t6_dec_at", da, 1);
    chk("t6_mis", {31'd0, misaligned}, 32'd1);
`else
    sb.push_back('{32'hCAFE_F00D, 1'b0, 1'b0});
    run_fetch(32'h102, 0, 0, 32'hCAFE_F00D, 2'b00, 32'h100, bc, dc, da, av);
    chk("t6_av", av, 1);
    chk("t6_dec_at", da, 3);
    chk("t6_err_clear", {31'd0, fetch_err}, 32'd0);
`endif

    // reset while in DATA
    @(negedge clock);
    enableFetch = 1'b1;
    pc = 32'h600;
    @(negedge clock);
    enableFetch = 1'b0;
    mem_arready = 1'b1;
    @(negedge clock);
    mem_arready = 1'b0;
    chk("t5_in_data", {31'd0, mem_rready}, 32'd1);
    #2;
    resetFetch = 1'b1;
    #1;
    chk("t5_arvalid", {31'd0, mem_arvalid}, 32'd0);
    chk("t5_rready", {31'd0, mem_rready}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_dec", {31'd0, enableDec}, 32'd0);
    chk("t5_inst", inst, NOP);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    @(negedge clock);
    resetFetch = 1'b0;
    mem_rvalid = 1'b0;
    repeat (3) @(negedge clock);
    chk("t5_idle", {31'd0, busy}, 32'd0);

    // recovery after reset
    sb.push_back('{32'h0040_0113, 1'b0, 1'b0});
    run_fetch(32'h704, 1, 1, 32'h0040_0113, 2'b00, 32'h704, bc, dc, da, av);
    chk("t7_busy", bc, 5);
    chk("t7_dec_cnt", dc, 1);

    repeat (2) @(negedge clock);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
